gcd_arbiter: RTL and testbench

Shares one subtractive GCD engine between `NREQ` independent requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. A round-robin scheduler grants one requester at a time, loads its operands into the engine, sequences the computation, and holds the result until the granted requester accepts it. It sits between the input-capture logic (switches/buttons or upstream blocks) and the result displays.

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_core.sv | 56 +++++
 rtl/gcd_arbiter.sv | 114 +++++++++++
 tb/tb_gcd_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD arbiter slice.
// GCD_ARBITER_SIGNED_EN selects two's-complement operands.
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Magnitude of a w-bit two's-complement value held in the low bits
  function automatic logic [31:0] abs_w(
    input logic [31:0] x,
    input int unsigned w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (x[w-1]) return (~x + 32'd1) & m;
    return x & m;
  endfunction

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD engine: operand registers, step/done logic, result.
// GCD_ARBITER_SIGNED_EN takes operand magnitudes at load time.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_result
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res;
  logic [W-1:0] w_la;
  logic [W-1:0] w_lb;
  logic [W-1:0] w_sel;

`ifdef GCD_ARBITER_SIGNED_EN
  assign w_la = W'(abs_w(32'(i_a), W));
  assign w_lb = W'(abs_w(32'(i_b), W));
`else
  assign w_la = i_a;
  assign w_lb = i_b;
`endif

  assign o_done = (r_a == '0) || (r_b == '0) || (r_a == r_b);
  assign w_sel  = (r_a == '0) ? r_b : r_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else if (i_load) begin
      r_a <= w_la;
      r_b <= w_lb;
    end else if (i_step) begin
      if (o_done)
        r_res <= w_sel;
      else if (r_a > r_b)
        r_a <= r_a - r_b;
      else
        r_b <= r_b - r_a;
    end
  end

  assign o_result = r_res;

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine between NREQ requesters.
// GCD_ARBITER_SIGNED_EN (see gcd_core) enables signed operands.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = GCD_W,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_result,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  state_e          r_state;
  state_e          w_state_n;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   w_pick;
  logic            w_found;
  logic            w_load;
  logic            w_done;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    w_res;
  logic [NREQ-1:0] w_pick_oh;
  logic [NREQ-1:0] w_gnt_oh;

  // Search starts just past the last granted requester
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(v_idx);
      end
    end
  end

  always_comb begin
    w_a = req_a[int'(w_pick)*W +: W];
    w_b = req_b[int'(w_pick)*W +: W];
  end

  assign w_pick_oh = NREQ'(1) << w_pick;
  assign w_gnt_oh  = NREQ'(1) << r_grant;

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    req_ready = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found && !rst) begin
          req_ready = w_pick_oh;
          w_load    = 1'b1;
          w_state_n = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_done) w_state_n = ST_RESP;
      end
      ST_RESP: begin
        if (|(rsp_ready & w_gnt_oh)) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= GW'(NREQ - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_load) begin
        r_last  <= w_pick;
        r_grant <= w_pick;
      end
    end
  end

  gcd_core #(
    .W(W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (r_state == ST_CALC),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_done   (w_done),
    .o_result (w_res)
  );

  assign rsp_valid  = (r_state == ST_RESP) ? w_gnt_oh : '0;
  assign rsp_result = (r_state == ST_RESP) ? w_res : '0;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_grant;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a transaction-level reference model.
// Honours GCD_ARBITER_SIGNED_EN for the signed-operand case.
module tb_gcd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int GW   = 2;
  localparam int BUDGET = 400;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_result;
  logic [NREQ-1:0]   rsp_ready;
  logic              busy;
  logic [GW-1:0]     grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_arbiter #(
    .NREQ(NREQ),
    .W(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gcd_f(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractions needed = sum of Euclid quotients minus one
  function automatic int steps_f(input int a, input int b);
    int s, t;
    if (a == 0 || b == 0) return 0;
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s - 1;
  endfunction

  function automatic int mag(input logic [W-1:0] x);
`ifdef GCD_ARBITER_SIGNED_EN
    if (x[W-1]) return (1 << W) - int'(x);
`endif
    return int'(x);
  endfunction

  int m_st    = 0;
  int m_cnt   = 0;
  int m_last  = NREQ - 1;
  int m_grant = 0;
  int m_res   = 0;

  always @(negedge clk) begin
    int pick, idx, ea, eb;
    logic [NREQ-1:0] e_rdy, e_val;
    pick = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (pick < 0 && req_valid[idx]) pick = idx;
    end
    e_rdy = '0;
    if (m_st == 0 && pick >= 0 && !rst) e_rdy[pick] = 1'b1;
    e_val = '0;
    if (m_st == 2) e_val[m_grant] = 1'b1;
    chk("m_req_ready", req_ready, e_rdy);
    chk("m_rsp_valid", rsp_valid, e_val);
    chk("m_rsp_result", rsp_result, (m_st == 2) ? m_res : 0);
    chk("m_busy", busy, m_st != 0);
    chk("m_grant_id", grant_id, m_grant);
    if (rst) begin
      m_st = 0; m_last = NREQ - 1; m_grant = 0; m_res = 0;
    end else if (m_st == 0) begin
      if (pick >= 0) begin
        ea = mag(req_a[pick*W +: W]);
        eb = mag(req_b[pick*W +: W]);
        m_res = gcd_f(ea, eb);
        m_cnt = steps_f(ea, eb);
        m_grant = pick;
        m_last = pick;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (m_cnt == 0) m_st = 2;
      else m_cnt--;
    end else begin
      if (rsp_ready[m_grant]) m_st = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic wait_accept(input int i);
    #1;
    for (int c = 0; c < BUDGET; c++) begin
      if (req_ready[i]) return;
      @(posedge clk);
      #2;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_any(output logic [NREQ-1:0] oh);
    oh = '0;
    #1;
    for (int c = 0; c < BUDGET; c++) begin
      if (req_ready != '0) begin
        oh = req_ready;
        return;
      end
      @(posedge clk);
      #2;
    end
    chk("any_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < BUDGET; c++) begin
      if (!busy) return;
      tick();
    end
    chk("idle_timeout", 0, 1);
  endtask

  // Called in the accept cycle; returns in the first rsp_valid cycle
  task automatic finish_txn(input int i, input int exp_res,
                            input int exp_lat, input string nm);
    int n;
    tick();
    req_valid[i] = 1'b0;
    n = 1;
    while (!rsp_valid[i] && n < BUDGET) begin
      tick();
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_res"}, rsp_result, exp_res);
  endtask

  task automatic do_txn(input int i, input int a, input int b,
                        input int exp_res, input int exp_lat,
                        input string nm);
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    wait_accept(i);
    finish_txn(i, exp_res, exp_lat, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] oh;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    tick();

    // Basic latency/result, zero operands
    do_txn(0, 12, 8, 4, 4, "t1");
    tick();
    chk("t1_busy_after", busy, 0);
    do_txn(0, 0, 5, 5, 2, "t2a");
    do_txn(0, 0, 0, 0, 2, "t2b");
    tick();
    wait_idle();

    // Round-robin from reset, all requesters pending
    for (int i = 0; i < NREQ; i++) set_ops(i, 6, 4);
    rst = 1'b1;
    req_valid = '1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      wait_any(oh);
      chk("t3_grant", oh, 1 << k);
      tick();
      req_valid[k] = 1'b0;
      if (k == NREQ - 1) req_valid[0] = 1'b1;
    end
    wait_any(oh);
    chk("t3_regrant0", oh, 1);
    finish_txn(0, 2, 4, "t3_req0");
    tick();
    wait_idle();

    // Back-pressure on requester 2 while requester 1 waits
    rsp_ready = 4'b1011;
    do_txn(2, 21, 14, 7, 4, "t4");
    set_ops(1, 9, 6);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("t4_hold_valid", rsp_valid, 4'b0100);
      chk("t4_hold_res", rsp_result, 7);
      chk("t4_no_accept", req_ready, 0);
      tick();
    end
    rsp_ready[2] = 1'b1;
    tick();
    chk("t4_req1_accept", req_ready, 4'b0010);
    finish_txn(1, 3, 4, "t4_req1");
    tick();
    wait_idle();

    // Reset during a long computation
    set_ops(1, 255, 1);
    req_valid[1] = 1'b1;
    wait_accept(1);
    for (int c = 0; c < 5; c++) tick();
    chk("t5_pre_grant", grant_id, 1);
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_result", rsp_result, 0);
    chk("t5_grant_id", grant_id, 0);
    wait_accept(1);
    chk("t5_reaccept", req_ready, 4'b0010);
    finish_txn(1, 1, 256, "t5");
    tick();
    wait_idle();

    // Negative operand
`ifdef GCD_ARBITER_SIGNED_EN
    do_txn(3, 8'hF4, 18, 6, 4, "t6");
`else
    do_txn(3, 8'hF4, 18, 2, 20, "t6");
`endif
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
